// File: rtl/synth_pkg.sv
// Shared constants, parser state encoding and the MIDI note frequency table
// (Hz * 1024, rounded to nearest) for the 8-voice synthesizer front end.
package synth_pkg;

  localparam int unsigned NUM_VOICES = 8;

  localparam logic [3:0] NOTE_OFF      = 4'h8;
  localparam logic [3:0] NOTE_ON       = 4'h9;
  localparam logic [3:0] POLY_PRESSURE = 4'hA;
  localparam logic [3:0] CC            = 4'hB;
  localparam logic [3:0] PITCH_BEND    = 4'hE;

  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_D1,
    ST_D2,
    ST_APPLY
  } parser_state_t;

  typedef logic [127:0][31:0] freq_table_t;

  // Equal temperament around A4 = 440 Hz; evaluated only at elaboration time.
  function automatic logic [31:0] note_freq_calc(input int unsigned k);
    real f;
    f = 450560.0 * (2.0 ** ((real'(k) - 69.0) / 12.0));
    return 32'($rtoi(f + 0.5));
  endfunction

  function automatic freq_table_t build_freq_table();
    freq_table_t t;
    for (int unsigned k = 0; k < 128; k++) begin
      t[k[6:0]] = note_freq_calc(k);
    end
    return t;
  endfunction

  localparam freq_table_t NOTE_FREQ = build_freq_table();

endpackage

// File: rtl/midi_parser.sv
// MIDI byte parser: classifies bytes, tracks running status and emits a
// one-cycle message strobe (status, d1, d2) one cycle after the APPLY state.
module midi_parser
  import synth_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] midi_byte,
  input  logic       midi_valid,
  output logic       midi_ready,
  output logic       msg_valid,
  output logic [7:0] msg_status,
  output logic [6:0] msg_d1,
  output logic [6:0] msg_d2
);

  parser_state_t state;
  logic [7:0]    running;
  logic [6:0]    d1;
  logic          two_data;
  logic          accept;

  always_comb begin
    two_data = 1'b0;
    case (running[7:4])
      NOTE_OFF, NOTE_ON, POLY_PRESSURE, CC, PITCH_BEND: two_data = 1'b1;
      default:                                          two_data = 1'b0;
    endcase
  end

  assign accept = midi_valid && midi_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      running    <= '0;
      d1         <= '0;
      midi_ready <= 1'b1;
      msg_valid  <= 1'b0;
      msg_status <= '0;
      msg_d1     <= '0;
      msg_d2     <= '0;
    end else begin
      msg_valid <= 1'b0;
      if (state == ST_APPLY) begin
        state      <= ST_D1;
        midi_ready <= 1'b1;
        msg_valid  <= 1'b1;
      end else if (accept) begin
        if (midi_byte[7:4] == 4'hF) begin
          // Real-time bytes (F8-FF) leave the parser untouched.
          if (!midi_byte[3]) begin
            state   <= ST_IDLE;
            running <= '0;
          end
        end else if (midi_byte[7]) begin
          running <= midi_byte;
          state   <= ST_D1;
        end else begin
          case (state)
            ST_D1: begin
              if (two_data) begin
                d1    <= midi_byte[6:0];
                state <= ST_D2;
              end
            end
            ST_D2: begin
              msg_status <= running;
              msg_d1     <= d1;
              msg_d2     <= midi_byte[6:0];
              state      <= ST_APPLY;
              midi_ready <= 1'b0;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/midi_voice_allocator.sv
// MIDI-to-voice allocator: turns parsed channel messages into registered
// per-voice frequency/volume/active controls for the 8-voice synthesizer.
module midi_voice_allocator
  import synth_pkg::*;
#(
  parameter int unsigned CHANNEL      = 0,
  parameter int unsigned VOLUME_SHIFT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  midi_byte,
  input  logic        midi_valid,
  output logic        midi_ready,
  output logic [31:0] frequencies   [NUM_VOICES-1:0],
  output logic [31:0] voice_volumes [NUM_VOICES-1:0],
  output logic [7:0]  voice_active
);

  logic       msg_valid;
  logic [7:0] msg_status;
  logic [6:0] msg_d1;
  logic [6:0] msg_d2;

  midi_parser u_parser (
    .clk        (clk),
    .reset_n    (reset_n),
    .midi_byte  (midi_byte),
    .midi_valid (midi_valid),
    .midi_ready (midi_ready),
    .msg_valid  (msg_valid),
    .msg_status (msg_status),
    .msg_d1     (msg_d1),
    .msg_d2     (msg_d2)
  );

  logic [6:0]  voice_note [NUM_VOICES];
  logic [2:0]  voice_age  [NUM_VOICES];

  logic        on_channel;
  logic        do_alloc;
  logic        do_release;
  logic        do_all_off;
  logic [31:0] new_volume;

  assign on_channel = msg_valid && (msg_status[3:0] == 4'(CHANNEL));
  assign do_alloc   = on_channel && (msg_status[7:4] == NOTE_ON) && (msg_d2 != '0);
  assign do_release = on_channel && ((msg_status[7:4] == NOTE_OFF) ||
                                     ((msg_status[7:4] == NOTE_ON) && (msg_d2 == '0)));
  assign do_all_off = on_channel && (msg_status[7:4] == CC) && (msg_d1 == CC_ALL_NOTES_OFF);
  assign new_volume = 32'(msg_d2) << VOLUME_SHIFT;

  logic       hit_found;
  logic [2:0] hit_idx;
  logic       free_found;
  logic [2:0] free_idx;
  logic [2:0] old_idx;
  logic [2:0] old_age;
  logic [2:0] target;

  // Strict '>' on age keeps the lowest index on ties; it only matters when every voice is busy.
  always_comb begin
    hit_found  = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    old_idx    = '0;
    old_age    = voice_age[0];
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (!hit_found && voice_active[i] && (voice_note[i] == msg_d1)) begin
        hit_found = 1'b1;
        hit_idx   = 3'(i);
      end
      if (!free_found && !voice_active[i]) begin
        free_found = 1'b1;
        free_idx   = 3'(i);
      end
      if (voice_age[i] > old_age) begin
        old_age = voice_age[i];
        old_idx = 3'(i);
      end
    end
    target = hit_found ? hit_idx : (free_found ? free_idx : old_idx);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      voice_active <= '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        frequencies[i]   <= NOTE_FREQ[69];
        voice_volumes[i] <= '0;
        voice_note[i]    <= '0;
        voice_age[i]     <= '0;
      end
    end else if (do_all_off) begin
      voice_active <= '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        voice_volumes[i] <= '0;
      end
    end else if (do_release) begin
      // Frequency is held on release so the oscillator never sees a step.
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        if (voice_active[i] && (voice_note[i] == msg_d1)) begin
          voice_volumes[i] <= '0;
          voice_active[i]  <= 1'b0;
        end
      end
    end else if (do_alloc) begin
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        if (3'(i) == target) begin
          frequencies[i]   <= NOTE_FREQ[msg_d1];
          voice_volumes[i] <= new_volume;
          voice_active[i]  <= 1'b1;
          voice_note[i]    <= msg_d1;
          voice_age[i]     <= '0;
        end else if (voice_active[i] && (voice_age[i] != 3'd7)) begin
          voice_age[i] <= voice_age[i] + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Scoreboard bench for midi_voice_allocator: stimulus pushes hand-computed
// expectations; a monitor pops one per completed message and compares.
module tb_midi_voice_allocator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  midi_byte = '0;
  logic        midi_valid = 1'b0;
  logic        midi_ready;
  logic [31:0] frequencies   [7:0];
  logic [31:0] voice_volumes [7:0];
  logic [7:0]  voice_active;

  midi_voice_allocator #(.CHANNEL(0), .VOLUME_SHIFT(16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .midi_byte     (midi_byte),
    .midi_valid    (midi_valid),
    .midi_ready    (midi_ready),
    .frequencies   (frequencies),
    .voice_volumes (voice_volumes),
    .voice_active  (voice_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  active;
    int          voice;
    logic [31:0] freq;
    logic [31:0] vol;
    bit          silent;
  } exp_t;

  exp_t  exp_q   [$];
  string exp_nm  [$];
  int    total = 0;
  int    bad   = 0;

  localparam logic [31:0] F_RESET = 32'd450560;
  localparam logic [31:0] V_40    = 32'd4194304;
  // Notes 60..68 at Hz*1024, hand-rounded.
  logic [31:0] exp_f [9] = '{32'd267905, 32'd283835, 32'd300713, 32'd318594, 32'd337539,
                             32'd357610, 32'd378874, 32'd401403, 32'd425272};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, want, want);
    end
  endtask

  task automatic expect_apply(input string nm, input logic [7:0] act, input int v,
                              input logic [31:0] f, input logic [31:0] vol, input bit silent);
    exp_t e;
    e.active = act; e.voice = v; e.freq = f; e.vol = vol; e.silent = silent;
    exp_q.push_back(e);
    exp_nm.push_back(nm);
  endtask

  // Called at a negedge; holds the byte until the DUT accepts it.
  task automatic send(input logic [7:0] b);
    int unsigned waitc;
    waitc = 0;
    midi_byte  = b;
    midi_valid = 1'b1;
    while (!midi_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!midi_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: byte 0x%0h not accepted, ready=%0b expected 1", b, midi_ready);
    end
    @(posedge clk);
    @(negedge clk);
    midi_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned waitc;
    waitc = 0;
    while (exp_q.size() != 0 && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    repeat (4) @(negedge clk);
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Monitor: a ready-low run marks APPLY; outputs are compared one cycle after ready returns.
  initial begin
    int    low_run;
    int    pending;
    exp_t  e;
    string nm;
    low_run = 0;
    pending = 0;
    forever begin
      @(negedge clk);
      if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_apply: active=0x%0h expected no message", voice_active);
          end else begin
            e  = exp_q.pop_front();
            nm = exp_nm.pop_front();
            chk({nm, "_active"}, 32'(voice_active), 32'(e.active));
            if (e.voice >= 0) begin
              chk({nm, "_freq"}, frequencies[e.voice], e.freq);
              chk({nm, "_vol"}, voice_volumes[e.voice], e.vol);
            end
            if (e.silent) begin
              for (int i = 0; i < 8; i++) chk({nm, "_silent"}, voice_volumes[i], 32'd0);
            end
          end
        end
      end
      if (!reset_n) begin
        low_run = 0;
      end else if (!midi_ready) begin
        low_run++;
      end else if (low_run > 0) begin
        chk("ready_low_cycles", 32'(low_run), 32'd1);
        low_run = 0;
        pending = 1;
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("reset_ready", 32'(midi_ready), 32'd1);
    chk("reset_active", 32'(voice_active), 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("reset_freq", frequencies[i], F_RESET);
      chk("reset_vol", voice_volumes[i], 32'd0);
    end

    // Single note A4, velocity 100
    expect_apply("single", 8'h01, 0, F_RESET, 32'd6553600, 1'b0);
    send(8'h90); send(8'h45); send(8'h64);
    drain();

    // Running status: two notes with one status byte
    do_reset();
    expect_apply("rs_n60", 8'h01, 0, exp_f[0], V_40, 1'b0);
    expect_apply("rs_n62", 8'h03, 1, exp_f[2], V_40, 1'b0);
    send(8'h90); send(8'h3C); send(8'h40); send(8'h3E); send(8'h40);
    drain();

    // Voice stealing, oldest-voice selection and retrigger
    do_reset();
    send(8'h90);
    for (int i = 0; i < 8; i++) begin
      int a;
      a = (1 << (i + 1)) - 1;
      expect_apply("fill", 8'(a), i, exp_f[i], V_40, 1'b0);
      send(8'(60 + i)); send(8'h40);
    end
    expect_apply("steal_v0", 8'hFF, 0, exp_f[8], V_40, 1'b0);
    send(8'h44); send(8'h40);
    expect_apply("steal_v1", 8'hFF, 1, F_RESET, V_40, 1'b0);
    send(8'h45); send(8'h40);
    expect_apply("retrigger_v2", 8'hFF, 2, exp_f[2], 32'd8323072, 1'b0);
    send(8'h3E); send(8'h7F);
    drain();
    for (int i = 3; i < 8; i++) chk("steal_untouched_freq", frequencies[i], exp_f[i]);
    chk("steal_untouched_vol7", voice_volumes[7], V_40);

    // Filtering and release
    do_reset();
    expect_apply("realtime_ignored", 8'h01, 0, exp_f[0], V_40, 1'b0);
    send(8'h90); send(8'h3C); send(8'hF8); send(8'h40);
    expect_apply("other_channel", 8'h01, 0, exp_f[0], V_40, 1'b0);
    send(8'h91); send(8'h3C); send(8'h00);
    expect_apply("note_off", 8'h00, 0, exp_f[0], 32'd0, 1'b0);
    send(8'h80); send(8'h3C); send(8'h00);
    expect_apply("off_not_sounding", 8'h00, 0, exp_f[0], 32'd0, 1'b0);
    send(8'h3D); send(8'h00);
    send(8'hF0); send(8'h3C); send(8'h40);
    send(8'hC0); send(8'h05); send(8'h06);
    drain();

    // Reset mid-message: trailing data byte must be dropped
    do_reset();
    send(8'h90); send(8'h3C);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send(8'h40);
    repeat (6) @(negedge clk);
    chk("midreset_active", 32'(voice_active), 32'd0);
    chk("midreset_vol0", voice_volumes[0], 32'd0);
    chk("midreset_freq0", frequencies[0], F_RESET);

    // Three notes, velocity-0 release, refill, unrelated CC, then all-notes-off
    expect_apply("three_a", 8'h01, 0, exp_f[0], V_40, 1'b0);
    expect_apply("three_b", 8'h03, 1, exp_f[1], V_40, 1'b0);
    expect_apply("three_c", 8'h07, 2, exp_f[2], V_40, 1'b0);
    send(8'h90); send(8'h3C); send(8'h40); send(8'h3D); send(8'h40); send(8'h3E); send(8'h40);
    expect_apply("vel0_release", 8'h05, 1, exp_f[1], 32'd0, 1'b0);
    send(8'h3D); send(8'h00);
    expect_apply("refill_lowest", 8'h07, 1, exp_f[3], V_40, 1'b0);
    send(8'h3F); send(8'h40);
    expect_apply("cc_other", 8'h07, 2, exp_f[2], V_40, 1'b0);
    send(8'hB0); send(8'h07); send(8'h64);
    expect_apply("all_notes_off", 8'h00, 0, exp_f[0], 32'd0, 1'b1);
    send(8'h7B); send(8'h00);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
